vga_sync_gen: RTL and testbench

Timing generator for the VGA output path. It produces HSYNC/VSYNC for the connector, and H_ON/V_ON plus pixel coordinates for the text circuit and the RGB colour stage. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical counters over a parameterised 640x480@60 Hz frame. It is the initiator of the H_ON/V_ON/pixel-position interface that the RGB colour stage consumes.

---
 rtl/vga_sync_gen_if.sv | 19 +
 rtl/vga_sync_gen.sv | 154 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA timing interface (sync, visible-region flags, pixel position, strobes)
interface vga_sync_gen_if;
    logic       HSYNC;
    logic       VSYNC;
    logic       H_ON;
    logic       V_ON;
    logic [9:0] PIX_X;
    logic [9:0] PIX_Y;
    logic       PIX_TICK;
    logic       FRAME_START;

    modport master (
        output HSYNC, VSYNC, H_ON, V_ON, PIX_X, PIX_Y, PIX_TICK, FRAME_START
    );

    modport slave (
        input HSYNC, VSYNC, H_ON, V_ON, PIX_X, PIX_Y, PIX_TICK, FRAME_START
    );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator; optional VGA_SYNC_DELAY_EN delays H_ON/V_ON/HSYNC/VSYNC by one pixel
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    vga_sync_gen_if.master    vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_h_on;
    logic       r_v_on;
    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic       r_pix_tick;
    logic       r_frame_start;

    logic       w_adv;
    logic       w_h_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_h_on;
    logic       w_v_on;
    logic       w_hsync;
    logic       w_vsync;

    assign w_adv    = (r_div == DIV_LAST);
    assign w_h_wrap = (r_h == H_LAST);
    assign w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
    assign w_v_next = w_h_wrap ? ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1) : r_v;

    // Decode from the post-advance position so registered outputs match the new pixel
    assign w_h_on  = (w_h_next < H_VIS);
    assign w_v_on  = (w_v_next < V_VIS);
    assign w_hsync = ((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    assign w_vsync = ((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;

    // Pixel-rate divider; the wrap edge is the advance
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div <= '0;
        end else begin
            r_div <= w_adv ? '0 : r_div + DIV_W'(1);
        end
    end

    // Position counters start at the last pixel so the first advance lands on (0,0)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h <= H_LAST;
            r_v <= V_LAST;
        end else if (w_adv) begin
            r_h <= w_h_next;
            r_v <= w_v_next;
        end
    end

    // Registered timing outputs, refreshed on every advance
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
            r_h_on  <= 1'b0;
            r_v_on  <= 1'b0;
            r_hsync <= ~SYNC_ACT;
            r_vsync <= ~SYNC_ACT;
        end else if (w_adv) begin
            r_pix_x <= w_h_next;
            r_pix_y <= w_v_next;
            r_h_on  <= w_h_on;
            r_v_on  <= w_v_on;
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
        end
    end

    // Single-clock strobes following each advance and the advance onto (0,0)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix_tick    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_tick    <= w_adv;
            r_frame_start <= w_adv && (w_h_next == 10'd0) && (w_v_next == 10'd0);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic r_hsync_d;
    logic r_vsync_d;
    logic r_h_on_d;
    logic r_v_on_d;

    // One-pixel lag on region/sync flags to match the font ROM read latency
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h_on_d  <= 1'b0;
            r_v_on_d  <= 1'b0;
            r_hsync_d <= ~SYNC_ACT;
            r_vsync_d <= ~SYNC_ACT;
        end else if (w_adv) begin
            r_h_on_d  <= r_h_on;
            r_v_on_d  <= r_v_on;
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign vga.HSYNC = r_hsync_d;
    assign vga.VSYNC = r_vsync_d;
    assign vga.H_ON  = r_h_on_d;
    assign vga.V_ON  = r_v_on_d;
`else
    assign vga.HSYNC = r_hsync;
    assign vga.VSYNC = r_vsync;
    assign vga.H_ON  = r_h_on;
    assign vga.V_ON  = r_v_on;
`endif

    assign vga.PIX_X       = r_pix_x;
    assign vga.PIX_Y       = r_pix_y;
    assign vga.PIX_TICK    = r_pix_tick;
    assign vga.FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen against an arithmetic timing model
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hon;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       fs;
    } vec_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int n_edges     = 0;
    bit done        = 1'b0;

    vec_t q_a[$];
    vec_t q_b[$];

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
    ) dut_a (
        .CLK(CLK), .RST_N(RST_N), .vga(if_a.master)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1)
    ) dut_b (
        .CLK(CLK), .RST_N(RST_N), .vga(if_b.master)
    );

    always #5 CLK = ~CLK;

    // Rising edges seen since the most recent reset release
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) n_edges = 0;
        else        n_edges = n_edges + 1;
    end

    // Expected outputs after n rising edges, from frame arithmetic: advance k lands on pixel (k-1) mod frame
    function automatic vec_t model(input int n, input int div,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input bit pol);
        vec_t r;
        int ht, vt, adv, idx, pidx, px, py;
        bit delayed;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        adv = n / div;
`ifdef VGA_SYNC_DELAY_EN
        delayed = 1'b1;
`else
        delayed = 1'b0;
`endif
        r.hs = ~pol; r.vs = ~pol; r.hon = 1'b0; r.von = 1'b0;
        r.x = '0; r.y = '0; r.tick = 1'b0; r.fs = 1'b0;
        if (adv >= 1) begin
            idx    = (adv - 1) % (ht * vt);
            r.x    = 10'(idx % ht);
            r.y    = 10'(idx / ht);
            r.tick = (n % div) == 0;
            r.fs   = r.tick && (idx == 0);
            if (!delayed || adv >= 2) begin
                pidx = delayed ? (adv - 2) % (ht * vt) : idx;
                px = pidx % ht;
                py = pidx / ht;
                r.hon = px < hd;
                r.von = py < vd;
                r.hs  = (px >= hd + hf && px < hd + hf + hsw) ? pol : ~pol;
                r.vs  = (py >= vd + vf && py < vd + vf + vsw) ? pol : ~pol;
            end
        end
        return r;
    endfunction

    // Expectation generator: after any reset activity in the cycle, predict what each DUT holds
    always @(posedge CLK) begin
        #3;
        if (!done) begin
            q_a.push_back(model(n_edges, 3, 10, 2, 3, 2, 6, 1, 2, 1, 1'b0));
            q_b.push_back(model(n_edges, 1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1));
        end
    end

    function automatic vec_t sample(input logic hs, input logic vs, input logic hon, input logic von,
                                    input logic [9:0] x, input logic [9:0] y,
                                    input logic tick, input logic fs);
        vec_t v;
        v = {hs, vs, hon, von, x, y, tick, fs};
        return v;
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s t=%0t got hs=%b vs=%b hon=%b von=%b x=%0d y=%0d tick=%b fs=%b want hs=%b vs=%b hon=%b von=%b x=%0d y=%0d tick=%b fs=%b",
                     name, $time, got.hs, got.vs, got.hon, got.von, got.x, got.y, got.tick, got.fs,
                     exp.hs, exp.vs, exp.hon, exp.von, exp.x, exp.y, exp.tick, exp.fs);
        end
    endtask

    // Monitor: pops one expectation per DUT per cycle and compares against the sampled outputs
    always @(negedge CLK) begin
        vec_t exp_v;
        if (!done) begin
            if (q_a.size() == 0 || q_b.size() == 0) begin
                vectors = vectors + 1;
                miscompares = miscompares + 1;
                $display("FAIL scoreboard_empty t=%0t got sizes %0d/%0d want nonempty", $time, q_a.size(), q_b.size());
            end else begin
                exp_v = q_a.pop_front();
                check("dut_a", sample(if_a.HSYNC, if_a.VSYNC, if_a.H_ON, if_a.V_ON,
                                      if_a.PIX_X, if_a.PIX_Y, if_a.PIX_TICK, if_a.FRAME_START), exp_v);
                exp_v = q_b.pop_front();
                check("dut_b", sample(if_b.HSYNC, if_b.VSYNC, if_b.H_ON, if_b.V_ON,
                                      if_b.PIX_X, if_b.PIX_Y, if_b.PIX_TICK, if_b.FRAME_START), exp_v);
            end
        end
    end

    // Reset pulse beginning between clock edges; k=0 is a pulse fully between two edges
    task automatic reset_pulse(input int k);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        if (k == 0) begin
            #1 RST_N = 1'b1;
        end else begin
            repeat (k) @(posedge CLK);
            #1 RST_N = 1'b1;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        // Cover several full frames of both DUTs before any mid-frame reset
        repeat (1700) @(posedge CLK);
        for (int seg = 0; seg < 10; seg++) begin
            reset_pulse(int'($urandom_range(0, 3)));
            repeat (int'($urandom_range(20, 900))) @(posedge CLK);
        end
        reset_pulse(1);
        repeat (600) @(posedge CLK);
        @(negedge CLK);
        #1 done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
